// File: rtl/hilbert_cordic_mag.sv
// rtl/hilbert_cordic_mag.sv - iterative CORDIC vectoring: envelope magnitude and phase of an I/Q pair
module hilbert_cordic_mag #(
    parameter int W    = 16,
    parameter int ITER = 12
) (
    input  logic         clk,
    input  logic         rst_cnt,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] i_in,
    input  logic [W-1:0] q_in,
    output logic         out_valid,
    output logic [W:0]   mag,
    output logic [W-1:0] phase
);

    localparam int XW  = W + 2;
    localparam int LSH = (W >= 16) ? W - 16 : 0;
    localparam int RSH = (W < 16) ? 16 - W : 0;
    localparam int RND = (W < 16) ? (1 << (15 - W)) : 0;
    localparam logic [XW+15:0] MAG_MAX = {{(XW+15-W){1'b0}}, {(W+1){1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_ROT, S_ITER, S_SCALE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic signed [XW-1:0] r_x;
    logic signed [XW-1:0] r_y;
    logic [W-1:0]         r_z;
    logic [3:0]           r_k;
    logic                 r_zero;
    logic                 r_out_valid;
    logic [W:0]           r_mag;
    logic [W-1:0]         r_phase;

    logic                 w_accept;
    logic signed [XW-1:0] w_xs;
    logic signed [XW-1:0] w_ys;
    logic [W-1:0]         w_atan;
    logic signed [XW+15:0] w_xe;
    logic signed [XW+15:0] w_ke;
    logic signed [XW+15:0] w_prod;
    logic signed [XW+15:0] w_sh;
    logic [W:0]           w_mag_sat;

    // Angle table held at 2^16 = 360 degrees, rescaled to the configured phase width.
    function automatic logic [W-1:0] atan_lut(input logic [3:0] k);
        logic [31:0] a16;
        logic [31:0] v;
        case (k)
            4'd0:    a16 = 32'd8192;
            4'd1:    a16 = 32'd4836;
            4'd2:    a16 = 32'd2555;
            4'd3:    a16 = 32'd1297;
            4'd4:    a16 = 32'd651;
            4'd5:    a16 = 32'd326;
            4'd6:    a16 = 32'd163;
            4'd7:    a16 = 32'd81;
            4'd8:    a16 = 32'd41;
            4'd9:    a16 = 32'd20;
            4'd10:   a16 = 32'd10;
            4'd11:   a16 = 32'd5;
            4'd12:   a16 = 32'd3;
            4'd13:   a16 = 32'd1;
            4'd14:   a16 = 32'd1;
            default: a16 = 32'd0;
        endcase
        v = ((a16 << LSH) + RND) >> RSH;
        return v[W-1:0];
    endfunction

    assign in_ready  = (r_state == S_IDLE);
    assign w_accept  = in_valid && in_ready;
    assign w_xs      = r_x >>> r_k;
    assign w_ys      = r_y >>> r_k;
    assign w_atan    = atan_lut(r_k);

    // Undo the CORDIC gain: 19898/2^15 ~ 1/1.64676.
    assign w_xe      = {{16{r_x[XW-1]}}, r_x};
    assign w_ke      = (XW+16)'(19898);
    assign w_prod    = w_xe * w_ke;
    assign w_sh      = w_prod >>> 15;

    always_comb begin
        w_mag_sat = '0;
        if (w_sh[XW+15])
            w_mag_sat = '0;
        else if (w_sh > MAG_MAX)
            w_mag_sat = MAG_MAX[W:0];
        else
            w_mag_sat = w_sh[W:0];
    end

    always_ff @(posedge clk) begin
        if (rst_cnt)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ROT;
            S_ROT:   w_next = S_ITER;
            S_ITER:  if (r_k == 4'(ITER - 1)) w_next = S_SCALE;
            S_SCALE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_cnt) begin
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_k         <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_mag       <= '0;
            r_phase     <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x    <= {{2{i_in[W-1]}}, i_in};
                        r_y    <= {{2{q_in[W-1]}}, q_in};
                        r_z    <= '0;
                        r_zero <= (i_in == '0) && (q_in == '0);
                    end
                end
                S_ROT: begin
                    // Fold the left half-plane onto the right; the two guard bits absorb -(-2^(W-1)).
                    if (r_x[XW-1]) begin
                        r_x <= -r_x;
                        r_y <= -r_y;
                        r_z <= {1'b1, {(W-1){1'b0}}};
                    end
                    r_k <= '0;
                end
                S_ITER: begin
                    if (!r_y[XW-1]) begin
                        r_x <= r_x + w_ys;
                        r_y <= r_y - w_xs;
                        r_z <= r_z + w_atan;
                    end else begin
                        r_x <= r_x - w_ys;
                        r_y <= r_y + w_xs;
                        r_z <= r_z - w_atan;
                    end
                    r_k <= r_k + 4'd1;
                end
                S_SCALE: begin
                    r_out_valid <= 1'b1;
                    r_mag       <= r_zero ? '0 : w_mag_sat;
                    r_phase     <= r_zero ? '0 : r_z;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign mag       = r_mag;
    assign phase     = r_phase;

endmodule

// File: tb/tb_hilbert_cordic_mag.sv
// tb/tb_hilbert_cordic_mag.sv - scoreboard bench for hilbert_cordic_mag
module tb_hilbert_cordic_mag;

    localparam int W    = 16;
    localparam int ITER = 12;
    localparam int LAT  = ITER + 2;
    localparam int PER  = ITER + 3;

    logic         clk = 1'b0;
    logic         rst_cnt;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] i_in;
    logic [W-1:0] q_in;
    logic         out_valid;
    logic [W:0]   mag;
    logic [W-1:0] phase;

    always #5 clk = ~clk;

    hilbert_cordic_mag #(.W(W), .ITER(ITER)) dut (
        .clk       (clk),
        .rst_cnt   (rst_cnt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i_in      (i_in),
        .q_in      (q_in),
        .out_valid (out_valid),
        .mag       (mag),
        .phase     (phase)
    );

    typedef struct {
        int emag;
        int ephase;
        int tmag;
        int tph;
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   last_acc = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp, input int tol, input bit wrap);
        int d;
        n_vec++;
        d = obs - exp;
        if (wrap) begin
            d = d & ((1 << W) - 1);
            if (d >= (1 << (W - 1))) d = d - (1 << W);
        end
        if (d > tol || d < -tol) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
        end
    endtask

    function automatic exp_t model(input int i, input int q, input int tmag);
        exp_t e;
        real  pi;
        real  ph;
        pi = 3.14159265358979;
        e.tmag = tmag;
        e.tph  = 4;
        e.acc_cyc = 0;
        if (i == 0 && q == 0) begin
            e.emag = 0;
            e.ephase = 0;
            e.tmag = 0;
            e.tph  = 0;
        end else begin
            e.emag = int'($floor($sqrt(real'(i) * real'(i) + real'(q) * real'(q)) + 0.5));
            ph = $atan2(real'(q), real'(i)) / (2.0 * pi) * real'(1 << W);
            e.ephase = int'($floor(ph + 0.5)) & ((1 << W) - 1);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            check("ov_pulse", int'(prev_ov), 0, 0, 1'b0);
            if (sb.size() == 0) begin
                check("spurious_ov", 1, 0, 0, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check("latency", cyc - mon_e.acc_cyc, LAT, 0, 1'b0);
                check("mag", int'(mag), mon_e.emag, mon_e.tmag, 1'b0);
                check("phase", int'(phase), mon_e.ephase, mon_e.tph, 1'b1);
            end
        end
        prev_ov = out_valid;
    end

    task automatic send(input int i, input int q, input int tmag, input bit hold);
        exp_t e;
        int   n;
        @(negedge clk);
        in_valid = 1'b1;
        i_in     = W'(i);
        q_in     = W'(q);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1, 0, 1'b0);
            in_valid = 1'b0;
        end else begin
            e = model(i, q, tmag);
            e.acc_cyc = cyc + 1;
            last_acc  = cyc + 1;
            sb.push_back(e);
            @(posedge clk);
            #1;
            check("rdy_busy", int'(in_ready), 0, 0, 1'b0);
            if (!hold) in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", sb.size(), 0, 0, 1'b0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int bi[4];
        int bq[4];
        int acc;
        int prev_acc;

        rst_cnt  = 1'b1;
        in_valid = 1'b1;
        i_in     = W'(1234);
        q_in     = W'(-4321);
        repeat (4) @(negedge clk);
        check("rst_ov", int'(out_valid), 0, 0, 1'b0);
        check("rst_mag", int'(mag), 0, 0, 1'b0);
        check("rst_phase", int'(phase), 0, 0, 1'b0);
        rst_cnt  = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", int'(in_ready), 1, 0, 1'b0);

        send(16384, 0, 4, 1'b0);       drain();
        send(0, 16384, 4, 1'b0);       drain();
        send(-16384, 0, 4, 1'b0);      drain();
        send(-10000, -10000, 4, 1'b0); drain();
        send(-32768, -32768, 8, 1'b0); drain();
        send(0, 0, 0, 1'b0);           drain();

        bi = '{3000, -3000, 5000, -20000};
        bq = '{4000, 4000, -12000, -7000};
        prev_acc = 0;
        for (int j = 0; j < 4; j++) begin
            send(bi[j], bq[j], 4, (j != 3));
            acc = last_acc;
            if (j > 0) check("b2b_spacing", acc - prev_acc, PER, 0, 1'b0);
            prev_acc = acc;
        end
        drain();

        send(1000, 2000, 4, 1'b0);
        acc = last_acc;
        while (cyc < acc + 6) @(negedge clk);
        rst_cnt = 1'b1;
        @(negedge clk);
        rst_cnt = 1'b0;
        sb.delete();
        check("midrst_mag", int'(mag), 0, 0, 1'b0);
        check("midrst_phase", int'(phase), 0, 0, 1'b0);
        check("midrst_ov", int'(out_valid), 0, 0, 1'b0);
        @(negedge clk);
        check("midrst_rdy", int'(in_ready), 1, 0, 1'b0);
        repeat (25) @(negedge clk);
        check("midrst_mag_hold", int'(mag), 0, 0, 1'b0);

        send(3000, 4000, 4, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
